// File: rtl/aritmetica_seq_pkg.sv
// Shared state encoding and default constants for the audio arithmetic sequencer.
package aritmetica_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILT = 2'd1,
        ST_WAIT = 2'd2,
        ST_DAC  = 2'd3
    } seq_state_e;

    localparam int DEF_P           = 10;
    localparam int DEF_F           = 14;
    localparam int DEF_LATENCY     = 2;
    localparam int DEF_DAC_TIMEOUT = 255;
    localparam int CNT_W           = 8;

endpackage

// File: rtl/aritmetica_sequencer_counter.sv
// Loadable down-counter with zero flag, reused for datapath latency and DAC timeout.
module seq_down_counter
    import aritmetica_seq_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         sclk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // A load takes priority over a decrement issued in the same cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge sclk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/aritmetica_sequencer.sv
// Per-sample controller: latches an ADC sample, strobes the filter bank, waits the
// datapath latency, then hands the result to the DAC driver with a timeout.
module aritmetica_sequencer
    import aritmetica_seq_pkg::*;
#(
    parameter int P           = DEF_P,
    parameter int F           = DEF_F,
    parameter int WIDTH       = P + F + 1,
    parameter int LATENCY     = DEF_LATENCY,
    parameter int DAC_TIMEOUT = DEF_DAC_TIMEOUT
) (
    input  logic             sclk,
    input  logic             rst,
    input  logic             adc_done,
    input  logic [WIDTH-1:0] adc_sample,
    input  logic [1:0]       gain_req1,
    input  logic [1:0]       gain_req2,
    input  logic [1:0]       gain_req3,
    output logic [WIDTH-1:0] arit_dato_adc,
    output logic             arit_enable,
    output logic [1:0]       arit_gain1,
    output logic [1:0]       arit_gain2,
    output logic [1:0]       arit_gain3,
    input  logic [WIDTH-1:0] arit_dato_dac,
    output logic [WIDTH-1:0] dac_data,
    output logic             dac_start,
    input  logic             dac_done,
    input  logic             clear_flags,
    output logic             busy,
    output logic             overrun,
    output logic             dac_timeout
);

    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(LATENCY - 1);
    localparam logic [CNT_W-1:0] TO_LOAD  = CNT_W'(DAC_TIMEOUT - 1);

    seq_state_e       state_q, state_d;
    logic [WIDTH-1:0] dato_adc_q, dato_adc_d;
    logic [WIDTH-1:0] dac_data_q, dac_data_d;
    logic [1:0]       gain1_q, gain1_d, gain2_q, gain2_d, gain3_q, gain3_d;
    logic             enable_q, enable_d;
    logic             dac_start_q, dac_start_d;
    logic             busy_q, busy_d;
    logic             overrun_q, overrun_d;
    logic             timeout_q, timeout_d;
    logic             timeout_set;
    logic             cnt_load, cnt_dec, cnt_zero;
    logic [CNT_W-1:0] cnt_val;

    seq_down_counter #(.W(CNT_W)) u_cnt (
        .sclk     (sclk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_d     = state_q;
        dato_adc_d  = dato_adc_q;
        dac_data_d  = dac_data_q;
        gain1_d     = gain1_q;
        gain2_d     = gain2_q;
        gain3_d     = gain3_q;
        enable_d    = 1'b0;
        dac_start_d = 1'b0;
        timeout_set = 1'b0;
        cnt_load    = 1'b0;
        cnt_dec     = 1'b0;
        cnt_val     = '0;
        case (state_q)
            ST_IDLE: begin
                if (adc_done) begin
                    dato_adc_d = adc_sample;
                    gain1_d    = gain_req1;
                    gain2_d    = gain_req2;
                    gain3_d    = gain_req3;
                    enable_d   = 1'b1;
                    state_d    = ST_FILT;
                end
            end
            ST_FILT: begin
                cnt_load = 1'b1;
                cnt_val  = LAT_LOAD;
                state_d  = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_zero) begin
                    dac_data_d  = arit_dato_dac;
                    dac_start_d = 1'b1;
                    cnt_load    = 1'b1;
                    cnt_val     = TO_LOAD;
                    state_d     = ST_DAC;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_DAC: begin
                // dac_done seen during the dac_start cycle is stale from the driver's
                // previous job and is ignored.
                if (dac_done && !dac_start_q) begin
                    state_d = ST_IDLE;
                end else if (cnt_zero) begin
                    timeout_set = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        overrun_d = (overrun_q & ~clear_flags) | (adc_done & (state_q != ST_IDLE));
        timeout_d = (timeout_q & ~clear_flags) | timeout_set;
        busy_d    = (state_d != ST_IDLE);
    end

    always_ff @(posedge sclk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            dato_adc_q  <= '0;
            dac_data_q  <= '0;
            gain1_q     <= '0;
            gain2_q     <= '0;
            gain3_q     <= '0;
            enable_q    <= 1'b0;
            dac_start_q <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            dato_adc_q  <= dato_adc_d;
            dac_data_q  <= dac_data_d;
            gain1_q     <= gain1_d;
            gain2_q     <= gain2_d;
            gain3_q     <= gain3_d;
            enable_q    <= enable_d;
            dac_start_q <= dac_start_d;
            busy_q      <= busy_d;
            overrun_q   <= overrun_d;
            timeout_q   <= timeout_d;
        end
    end

    assign arit_dato_adc = dato_adc_q;
    assign arit_enable   = enable_q;
    assign arit_gain1    = gain1_q;
    assign arit_gain2    = gain2_q;
    assign arit_gain3    = gain3_q;
    assign dac_data      = dac_data_q;
    assign dac_start     = dac_start_q;
    assign busy          = busy_q;
    assign overrun       = overrun_q;
    assign dac_timeout   = timeout_q;

endmodule

// File: tb/tb_aritmetica_sequencer.sv
// Self-checking bench: fixed vector table, randomized transactions against a
// transaction-level timing model, and hand sequences for flags and reset.
module tb_aritmetica_sequencer;

    localparam int WIDTH = 25;
    localparam int LAT   = 2;
    localparam int TO    = 255;

    logic             sclk = 1'b0;
    logic             rst = 1'b1;
    logic             adc_done = 1'b0;
    logic [WIDTH-1:0] adc_sample = '0;
    logic [1:0]       gain_req1 = '0, gain_req2 = '0, gain_req3 = '0;
    logic [WIDTH-1:0] arit_dato_adc;
    logic             arit_enable;
    logic [1:0]       arit_gain1, arit_gain2, arit_gain3;
    logic [WIDTH-1:0] arit_dato_dac = '0;
    logic [WIDTH-1:0] dac_data;
    logic             dac_start;
    logic             dac_done = 1'b0;
    logic             clear_flags = 1'b0;
    logic             busy, overrun, dac_timeout;

    aritmetica_sequencer #(
        .P(10), .F(14), .WIDTH(WIDTH), .LATENCY(LAT), .DAC_TIMEOUT(TO)
    ) dut (
        .sclk(sclk), .rst(rst), .adc_done(adc_done), .adc_sample(adc_sample),
        .gain_req1(gain_req1), .gain_req2(gain_req2), .gain_req3(gain_req3),
        .arit_dato_adc(arit_dato_adc), .arit_enable(arit_enable),
        .arit_gain1(arit_gain1), .arit_gain2(arit_gain2), .arit_gain3(arit_gain3),
        .arit_dato_dac(arit_dato_dac), .dac_data(dac_data), .dac_start(dac_start),
        .dac_done(dac_done), .clear_flags(clear_flags), .busy(busy),
        .overrun(overrun), .dac_timeout(dac_timeout)
    );

    always #5 sclk = ~sclk;

    int vectors = 0;
    int miscompares = 0;

    // done_d: edge (counted from the dac_start edge) whose sample sees a one-cycle
    // dac_done pulse, 0 = never. inj: edge after acceptance carrying an extra adc_done.
    typedef struct {
        logic [WIDTH-1:0] sample;
        logic [5:0]       g;
        logic [WIDTH-1:0] result;
        int               done_d;
        int               inj;
        int               exp_start;
        int               exp_idle;
        bit               exp_to;
        bit               exp_ovr;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge sclk);
        #1;
    endtask

    function automatic vec_t mk(input logic [WIDTH-1:0] s, input logic [5:0] g,
                                input logic [WIDTH-1:0] res, input int d, input int inj,
                                input int es, input int ei, input bit eto, input bit eovr);
        vec_t v;
        v.sample = s; v.g = g; v.result = res; v.done_d = d; v.inj = inj;
        v.exp_start = es; v.exp_idle = ei; v.exp_to = eto; v.exp_ovr = eovr;
        return v;
    endfunction

    // Reference timing: start LAT+1 edges after acceptance; a dac_done pulse counts
    // only from the second DAC-phase edge up to the timeout edge.
    function automatic vec_t model(input vec_t v);
        vec_t m = v;
        bit eff = (v.done_d >= 2) && (v.done_d <= TO);
        m.exp_start = LAT + 1;
        m.exp_idle  = LAT + 1 + (eff ? v.done_d : TO);
        m.exp_to    = !eff;
        m.exp_ovr   = (v.inj != 0);
        return m;
    endfunction

    task automatic run_vec(input vec_t v, input string tag);
        int en_cnt = 0, en_rel = -1, st_cnt = 0, st_rel = -1, idle_rel = -1;
        logic [WIDTH-1:0] st_data = '0;
        adc_sample    = v.sample;
        {gain_req1, gain_req2, gain_req3} = v.g;
        arit_dato_dac = v.result;
        adc_done      = 1'b1;
        tick;
        adc_done = 1'b0;
        for (int r = 0; r < 400 && idle_rel < 0; r++) begin
            if (arit_enable) begin en_cnt++; en_rel = r; end
            if (dac_start) begin st_cnt++; st_rel = r; st_data = dac_data; end
            if (!busy) begin
                idle_rel = r;
            end else begin
                dac_done  = (v.done_d > 0) && (r + 1 == LAT + 1 + v.done_d);
                adc_done  = (v.inj != 0) && (r + 1 == v.inj);
                if (adc_done) adc_sample = WIDTH'($urandom);
                gain_req1 = 2'($urandom);
                gain_req2 = 2'($urandom);
                gain_req3 = 2'($urandom);
                tick;
                dac_done = 1'b0;
                adc_done = 1'b0;
            end
        end
        check($sformatf("%s enable_count", tag), en_cnt, 1);
        check($sformatf("%s enable_edge", tag), en_rel, 0);
        check($sformatf("%s start_count", tag), st_cnt, 1);
        check($sformatf("%s start_edge", tag), st_rel, v.exp_start);
        check($sformatf("%s dac_data", tag), st_data, v.result);
        check($sformatf("%s idle_edge", tag), idle_rel, v.exp_idle);
        check($sformatf("%s dac_timeout", tag), dac_timeout, v.exp_to);
        check($sformatf("%s overrun", tag), overrun, v.exp_ovr);
        check($sformatf("%s arit_dato_adc", tag), arit_dato_adc, v.sample);
        check($sformatf("%s arit_gains", tag), {arit_gain1, arit_gain2, arit_gain3}, v.g);
        check($sformatf("%s dac_data_hold", tag), dac_data, v.result);
        clear_flags = 1'b1;
        tick;
        clear_flags = 1'b0;
        check($sformatf("%s flags_cleared", tag), {overrun, dac_timeout}, 2'b00);
    endtask

    vec_t tbl[7];

    initial begin
        tbl[0] = mk(25'h0012345, 6'b01_10_11, 25'h00ABCDE, 5,   0,   3, 8,   1'b0, 1'b0);
        tbl[1] = mk(25'h1FFFFFF, 6'b00_00_00, 25'h1000000, 2,   2,   3, 5,   1'b0, 1'b1);
        tbl[2] = mk(25'h0000001, 6'b11_00_01, 25'h0055555, 1,   0,   3, 258, 1'b1, 1'b0);
        tbl[3] = mk(25'h0AAAAAA, 6'b10_01_00, 25'h1555555, 0,   258, 3, 258, 1'b1, 1'b1);
        tbl[4] = mk(25'h0123456, 6'b01_01_01, 25'h0FEDCBA, 3,   0,   3, 6,   1'b0, 1'b0);
        tbl[5] = mk(25'h1800000, 6'b11_11_11, 25'h0000000, 255, 0,   3, 258, 1'b0, 1'b0);
        tbl[6] = mk(25'h0F0F0F0, 6'b10_10_10, 25'h0707070, 4,   1,   3, 7,   1'b0, 1'b1);

        tick; tick;
        rst = 1'b0;
        check("reset data", {arit_dato_adc, dac_data}, '0);
        check("reset gains", {arit_gain1, arit_gain2, arit_gain3}, '0);
        check("reset strobes", {arit_enable, dac_start}, 2'b00);
        check("reset status", {busy, overrun, dac_timeout}, 3'b000);
        tick;

        for (int i = 0; i < 7; i++) run_vec(tbl[i], $sformatf("tbl%0d", i));

        for (int i = 0; i < 20; i++) begin
            vec_t v;
            v.sample = WIDTH'($urandom);
            v.g      = 6'($urandom);
            v.result = WIDTH'($urandom);
            v.done_d = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 1) : $urandom_range(2, 14);
            v.inj    = 0;
            v = model(v);
            if ($urandom_range(0, 2) == 0) v.inj = $urandom_range(1, v.exp_idle);
            v = model(v);
            run_vec(v, $sformatf("rnd%0d", i));
        end

        // Overrun with clear in the same cycle, then a dac_done level held from the start cycle.
        adc_sample = 25'h0031337; adc_done = 1'b1; arit_dato_dac = 25'h0044444;
        tick;
        tick;
        check("ovr set", overrun, 1'b1);
        clear_flags = 1'b1;
        tick;
        check("ovr set_beats_clear", overrun, 1'b1);
        adc_done = 1'b0;
        tick;
        clear_flags = 1'b0;
        check("ovr cleared", overrun, 1'b0);
        check("lvl start", dac_start, 1'b1);
        dac_done = 1'b1;
        tick;
        check("lvl done_ignored_in_start_cycle", busy, 1'b1);
        tick;
        dac_done = 1'b0;
        check("lvl idle", busy, 1'b0);
        check("lvl no_timeout", dac_timeout, 1'b0);
        check("lvl arit_dato_adc", arit_dato_adc, 25'h0031337);
        tick;

        // Reset while waiting on the datapath.
        begin
            bit seen = 1'b0;
            adc_sample = 25'h0777777; adc_done = 1'b1;
            tick;
            adc_done = 1'b0;
            tick;
            check("rstw in_wait", busy, 1'b1);
            rst = 1'b1;
            tick;
            rst = 1'b0;
            check("rstw data", {arit_dato_adc, dac_data}, '0);
            check("rstw gains", {arit_gain1, arit_gain2, arit_gain3}, '0);
            check("rstw status", {arit_enable, dac_start, busy, overrun, dac_timeout}, '0);
            for (int k = 0; k < 6; k++) begin
                tick;
                if (dac_start || busy) seen = 1'b1;
            end
            check("rstw no_start_after", seen, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
